// File: rtl/pu_pkg.sv
// Shared PU definitions: control constants, default widths and the send-DMA
// state encoding.
package pu_pkg;

   localparam logic ASSERT = 1'b1;
   localparam logic NEGATE = 1'b0;

   localparam int PU_DW = 16;
   localparam int PU_AW = 8;
   localparam int PU_PW = 4;

   // Words the send DMA may have buffered or in flight from the data memory.
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } send_state_t;

endpackage

// File: rtl/pu_skid_fifo.sv
// Two-entry FIFO with fall-through: a word pushed into an empty FIFO is
// visible at head in the same cycle and may be popped without being stored.
module pu_skid_fifo
   import pu_pkg::*;
#(
   parameter int DW = PU_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [1:0]    count,
   output logic          avail
);

   logic [DW-1:0] mem [SKID_DEPTH];
   logic          wr_ptr;
   logic          rd_ptr;
   logic          store;
   logic          take;

   always_comb begin
      store = push && !(pop && (count == 2'd0));
      take  = pop && (count != 2'd0);
      avail = (count != 2'd0) || push;
      head  = '0;
      if (count != 2'd0) begin
         head = mem[rd_ptr];
      end else if (push) begin
         head = push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (store) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (take) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, store} - {1'b0, take};
      end
   end

endmodule

// File: rtl/pu_send_dma.sv
// SEND command engine: reads a block of data-memory words and streams them to
// the inter-PU link, stalling the PU via busy until the last word is accepted.
module pu_send_dma
   import pu_pkg::*;
#(
   parameter int DW = PU_DW,
   parameter int AW = PU_AW,
   parameter int PW = PU_PW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          send,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] size,
   input  logic [PW-1:0] port,
   output logic          busy,
   output logic          done,
   output logic          dm_re,
   output logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_rdata,
   output logic          tx_valid,
   output logic [DW-1:0] tx_data,
   output logic [PW-1:0] tx_port,
   output logic          tx_last,
   input  logic          tx_ready
);

   localparam logic [DW-1:0] ONE = DW'(1);

   send_state_t   state;
   send_state_t   state_next;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] rd_left;
   logic [DW-1:0] tx_left;
   logic          inflight;
   logic [1:0]    fifo_count;
   logic          has_credit;
   logic          tx_fire;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^addr[DW-1:AW];

   // Reads in flight count against the FIFO so returned data always has room.
   assign has_credit = ({1'b0, fifo_count} + {2'b0, inflight}) < 3'(SKID_DEPTH);
   assign tx_fire    = tx_valid && tx_ready;
   assign tx_last    = tx_valid && (tx_left == ONE);
   assign dm_addr    = dm_re ? cur_addr : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = NEGATE;
      dm_re      = NEGATE;
      case (state)
         IDLE: begin
            if (send) begin
               state_next = (size == '0) ? FIN : READ;
            end
         end
         READ: begin
            if ((rd_left != '0) && has_credit) begin
               dm_re = ASSERT;
            end
            if (dm_re && (rd_left == ONE)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (tx_fire && (tx_left == ONE)) begin
               state_next = FIN;
            end
         end
         FIN: begin
            done       = ASSERT;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr <= '0;
         rd_left  <= '0;
         tx_left  <= '0;
         tx_port  <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= dm_re;
         if ((state == IDLE) && send) begin
            cur_addr <= addr[AW-1:0];
            rd_left  <= size;
            tx_left  <= size;
            tx_port  <= port;
         end else begin
            if (dm_re) begin
               cur_addr <= cur_addr + AW'(1);
               rd_left  <= rd_left - ONE;
            end
            if (tx_fire) begin
               tx_left <= tx_left - ONE;
            end
         end
      end
   end

   pu_skid_fifo #(
      .DW (DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (dm_rdata),
      .pop       (tx_fire),
      .head      (tx_data),
      .count     (fifo_count),
      .avail     (tx_valid)
   );

endmodule

// File: tb/tb_pu_send_dma.sv
// Directed bench for pu_send_dma: data-memory model, stream scoreboard and
// cycle-pattern checks for latency, backpressure, reset abort and ignored sends.
module tb_pu_send_dma;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          send = 1'b0;
   logic [DW-1:0] addr = '0;
   logic [DW-1:0] size = '0;
   logic [PW-1:0] port = '0;
   logic          busy;
   logic          done;
   logic          dm_re;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_rdata;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic [PW-1:0] tx_port;
   logic          tx_last;
   logic          tx_ready = 1'b1;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] exp_q [$];
   logic          last_q [$];
   logic [AW-1:0] addr_q [$];
   logic [PW-1:0] exp_port;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;

   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic [15:0]   lg_re, lg_tv, lg_last, lg_done, lg_busy;

   pu_send_dma #(.DW(DW), .AW(AW), .PW(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .send     (send),
      .addr     (addr),
      .size     (size),
      .port     (port),
      .busy     (busy),
      .done     (done),
      .dm_re    (dm_re),
      .dm_addr  (dm_addr),
      .dm_rdata (dm_rdata),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_port  (tx_port),
      .tx_last  (tx_last),
      .tx_ready (tx_ready)
   );

   // clock / reset
   always #5 clk = ~clk;

   // data memory: read data valid the cycle after dm_re
   always @(posedge clk or posedge rst) begin
      if (rst) dm_rdata <= '0;
      else if (dm_re) dm_rdata <= mem[dm_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(prev_data));
         end
         if (dm_re) begin
            chk("addr_pending", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) chk("dm_addr", 32'(dm_addr), 32'(addr_q.pop_front()));
         end
         if (busy) chk("fifo_le2", 32'(dut.u_fifo.count <= 2'd2), 32'd1);
         if (done) done_cnt++;
         if (tx_valid && tx_ready) begin
            hs_cnt++;
            chk("word_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
               chk("tx_last", 32'(tx_last), 32'(last_q.pop_front()));
               chk("tx_port", 32'(tx_port), 32'(exp_port));
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   // driver: one-cycle send, expectations pushed as the command is issued
   task automatic do_send(input logic [DW-1:0] a, input logic [DW-1:0] s, input logic [PW-1:0] p);
      @(negedge clk);
      addr = a;
      size = s;
      port = p;
      send = 1'b1;
      exp_port = p;
      for (int i = 0; i < int'(s); i++) begin
         addr_q.push_back(AW'(a + DW'(i)));
         exp_q.push_back(mem[AW'(a + DW'(i))]);
         last_q.push_back(i == int'(s) - 1);
      end
      @(posedge clk);
      #1 send = 1'b0;
   endtask

   task automatic capture(input int n);
      lg_re = '0; lg_tv = '0; lg_last = '0; lg_done = '0; lg_busy = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         lg_re[k]   = dm_re;
         lg_tv[k]   = tx_valid;
         lg_last[k] = tx_last;
         lg_done[k] = done;
         lg_busy[k] = busy;
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_dm_re"}, 32'(dm_re), 32'd0);
      chk({tag, "_dm_addr"}, 32'(dm_addr), 32'd0);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_tx_port"}, 32'(tx_port), 32'd0);
      chk({tag, "_tx_last"}, 32'(tx_last), 32'd0);
   endtask

   initial begin
      int d0;
      logic ok;
      logic [5:0] pat;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 65535));

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // basic 3-word transfer, cycle-exact
      do_send(16'h0010, 16'd3, 4'd5);
      capture(7);
      chk("t1_dm_re", 32'(lg_re), 32'h000E);
      chk("t1_tx_valid", 32'(lg_tv), 32'h001C);
      chk("t1_tx_last", 32'(lg_last), 32'h0010);
      chk("t1_done", 32'(lg_done), 32'h0020);
      chk("t1_busy", 32'(lg_busy), 32'h003E);
      chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

      // zero-length transfer
      do_send(16'h0033, 16'd0, 4'd2);
      capture(4);
      chk("t2_dm_re", 32'(lg_re), 32'h0000);
      chk("t2_tx_valid", 32'(lg_tv), 32'h0000);
      chk("t2_done", 32'(lg_done), 32'h0002);
      chk("t2_busy", 32'(lg_busy), 32'h0002);

      // address wrap FE, FF, 00, 01
      do_send(16'h00FE, 16'd4, 4'd3);
      wait_idle("t3_timeout", 50);
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
      chk("t3_addr_q_empty", 32'(addr_q.size()), 32'd0);

      // backpressure pattern 1,0,0,1,0,1
      pat = 6'b101001;
      hs_cnt = 0;
      do_send(16'h0050, 16'd6, 4'd9);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1 tx_ready = pat[k % 6];
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      tx_ready = 1'b1;
      chk("t4_timeout", 32'(ok), 32'd1);
      chk("t4_words", 32'(hs_cnt), 32'd6);
      chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

      // reset after 2 of 5 words aborts with no done
      hs_cnt = 0;
      d0 = done_cnt;
      do_send(16'h0020, 16'd5, 4'd2);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (hs_cnt >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_timeout", 32'(ok), 32'd1);
      rst = 1'b1;
      #1;
      chk_outputs_zero("t5_abort");
      exp_q.delete();
      last_q.delete();
      addr_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_no_done", 32'(done_cnt), 32'(d0));
      chk("t5_idle", 32'(busy), 32'd0);
      do_send(16'h0030, 16'd2, 4'd7);
      wait_idle("t5_timeout2", 50);
      chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
      chk("t5_one_done", 32'(done_cnt), 32'(d0 + 1));

      // send while busy is ignored
      hs_cnt = 0;
      d0 = done_cnt;
      do_send(16'h0080, 16'd3, 4'd6);
      @(posedge clk);
      #1;
      addr = 16'h0090;
      size = 16'd5;
      port = 4'd1;
      send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
      wait_idle("t6_timeout", 50);
      repeat (4) @(negedge clk);
      chk("t6_words", 32'(hs_cnt), 32'd3);
      chk("t6_one_done", 32'(done_cnt), 32'(d0 + 1));
      chk("t6_idle", 32'(busy), 32'd0);
      chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
